fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of the team's 8-bit synchronous FIFO between two producers.
- Uses round-robin arbitration with bounded bursts.
- Drives the FIFO's data_in/we directly and honours its full flag; the FIFO read side is untouched.
- Sits between two producer blocks and one fifo_synchronous instance in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of producer data and FIFO data_in.
- BURST_LEN, 4, maximum words accepted from one producer per grant while the other producer is requesting (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  producer 0 has a word on data0.
- data0  input  DATA_WIDTH  producer 0 write data.
- gnt0  output  1  producer 0 owns the FIFO write port (registered).
- ack0  output  1  data0 is written to the FIFO this cycle.
- req1  input  1  producer 1 has a word on data1.
- data1  input  DATA_WIDTH  producer 1 write data.
- gnt1  output  1  producer 1 owns the FIFO write port (registered).
- ack1  output  1  data1 is written to the FIFO this cycle.
- fifo_full  input  1  full flag from the FIFO.
- fifo_we  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, GRANT0, GRANT1. gnt0 = (state==GRANT0) and gnt1 = (state==GRANT1), both decoded from the state register.
- Registers: state, last (last producer served), burst_cnt (counts accepted words in the current grant).
- Reset values after a clk edge with rst=1:
  - state=IDLE, last=1 (so producer 0 wins the first tie), burst_cnt=0.
  - gnt0=gnt1=0.
- Reset gating: fifo_we, ack0 and ack1 are forced to 0 combinationally whenever rst=1, including the cycle in which rst rises mid-burst.
- Accept rule (combinational):
  - ackK = gntK & reqK & ~fifo_full & ~rst.
  - fifo_we = ack0 | ack1.
  - fifo_data_in = data1 when gnt1, else data0 (including IDLE).
  - At most one ack is ever high.
- IDLE transitions:
  - req0 only -> GRANT0.
  - req1 only -> GRANT1.
  - Both -> the producer other than last.
  - Neither -> stay in IDLE.
  - Arbitration latency: a request first seen in IDLE is granted on the next edge and accepted no earlier than one cycle after req rises.
- GRANTk, on each clk edge:
  - If ackK: burst_cnt += 1, and last is set to k.
  - ReqK low (no ack): if the other producer is requesting, go to GRANT(other) with burst_cnt=0; otherwise go to IDLE with burst_cnt=0.
  - ackK and burst_cnt+1==BURST_LEN:
    - Other requesting: switch to GRANT(other), burst_cnt=0.
    - Other not requesting: stay in GRANTk, burst_cnt=0 (burst restarts).
  - Otherwise stay in GRANTk.
- Full stall:
  - While fifo_full=1 there is no ack and burst_cnt holds.
  - Grant is held as long as reqK stays high; there is no timeout.
  - Dropping reqK during full releases the grant per the rules above.
- Handshake rules:
  - A producer holds reqK and dataK stable until it sees ackK at a rising edge.
  - A producer may drop reqK only after an ack, or when it has no more data.
- Fairness: with both producers requesting continuously and the FIFO never full, grants alternate in bursts of exactly BURST_LEN words, with zero dead cycles between bursts.
- Switch-over: the same-edge handover means the new owner can be acked in the first cycle of its grant.
- burst_cnt width: 4 bits. It never exceeds BURST_LEN-1 between edges.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, fifo_we=0. The first edge after release -> gnt0=1.
- Single producer: req1=1, data1=8'hA0..A5 (advanced on each ack), BURST_LEN=4, fifo_full=0 -> gnt1 from cycle 2. Six consecutive acks with no gap (burst restart), FIFO receives A0..A5 in order.
- Contention: req0 and req1 continuously high, data0=8'h1x, data1=8'h2x -> fifo_data_in sequence 10,11,12,13,20,21,22,23,14,15,16,17.
- Full stall: producer 0 granted with burst_cnt=2, fifo_full=1 for 3 cycles -> fifo_we=0 and gnt0 held. After release -> two more acks, then switch to producer 1.
- Request drop: gnt0=1, req0 falls after 1 ack while req1=1 -> gnt1=1 on the next edge, burst_cnt=0, no lost or duplicated word.
- Reset mid-burst: rst=1 during a GRANT1 ack cycle -> fifo_we=0 in that cycle, state=IDLE after the edge. After release with both requesting -> producer 0 is granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_write_arbiter : round-robin, burst-bounded sharing of one FIFO write
//                      port between two producers.
// Revision: 1.0
// ============================================================================
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  gnt0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt1,
  output logic                  ack1,
  input  logic                  fifo_full,
  output logic                  fifo_we,
  output logic [DATA_WIDTH-1:0] fifo_data_in
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT0 = 2'd1;
  localparam logic [1:0] S_GRANT1 = 2'd2;
  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    burst_cnt_nxt = burst_cnt;
    case (state)
      S_IDLE: begin
        burst_cnt_nxt = 4'd0;
        if (req0 && req1)
          state_nxt = last ? S_GRANT0 : S_GRANT1;
        else if (req0)
          state_nxt = S_GRANT0;
        else if (req1)
          state_nxt = S_GRANT1;
      end
      S_GRANT0: begin
        if (ack0) begin
          last_nxt = 1'b0;
          if (burst_cnt == BURST_LAST) begin
            burst_cnt_nxt = 4'd0;
            if (req1) state_nxt = S_GRANT1;
          end else begin
            burst_cnt_nxt = burst_cnt + 4'd1;
          end
        end else if (!req0) begin
          burst_cnt_nxt = 4'd0;
          state_nxt     = req1 ? S_GRANT1 : S_IDLE;
        end
        // Otherwise a full stall: grant and count both hold.
      end
      S_GRANT1: begin
        if (ack1) begin
          last_nxt = 1'b1;
          if (burst_cnt == BURST_LAST) begin
            burst_cnt_nxt = 4'd0;
            if (req0) state_nxt = S_GRANT0;
          end else begin
            burst_cnt_nxt = burst_cnt + 4'd1;
          end
        end else if (!req1) begin
          burst_cnt_nxt = 4'd0;
          state_nxt     = req0 ? S_GRANT0 : S_IDLE;
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        burst_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Output decode; rst gates the write path in the same cycle it rises.
  always_comb begin
    gnt0         = (state == S_GRANT0);
    gnt1         = (state == S_GRANT1);
    ack0         = gnt0 & req0 & ~fifo_full & ~rst;
    ack1         = gnt1 & req1 & ~fifo_full & ~rst;
    fifo_we      = ack0 | ack1;
    fifo_data_in = gnt1 ? data1 : data0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_write_arbiter : directed self-checking bench for fifo_write_arbiter.
// Revision: 1.0
// ============================================================================
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1, ack0, ack1;
  logic [7:0] data0, data1, fifo_data_in;
  logic       fifo_full, fifo_we;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .data0        (data0),
    .gnt0         (gnt0),
    .ack0         (ack0),
    .req1         (req1),
    .data1        (data1),
    .gnt1         (gnt1),
    .ack1         (ack1),
    .fifo_full    (fifo_full),
    .fifo_we      (fifo_we),
    .fifo_data_in (fifo_data_in)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [7:0] exp_c [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
                             8'h22, 8'h23, 8'h14, 8'h15, 8'h16, 8'h17};

  initial begin
    // Reset held with both producers requesting
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; fifo_full = 1'b0;
    data0 = 8'h55; data1 = 8'h66;
    step();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_we", fifo_we, 0);
      step();
    end
    rst = 1'b0;
    sample();
    check("rel_idle_gnt0", gnt0, 0);
    check("rel_idle_we", fifo_we, 0);
    step();
    sample();
    check("rel_first_gnt0", gnt0, 1);
    check("rel_first_gnt1", gnt1, 0);
    check("rel_first_data", fifo_data_in, 8'h55);

    // Single producer: burst restarts with no gap
    step();
    do_reset();
    req1 = 1'b1; data1 = 8'hA0;
    sample();
    check("single_idle_gnt1", gnt1, 0);
    check("single_idle_we", fifo_we, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      sample();
      check("single_gnt1", gnt1, 1);
      check("single_we", fifo_we, 1);
      check("single_data", fifo_data_in, 8'hA0 + i);
      step();
      data1 = data1 + 8'd1;
    end
    req1 = 1'b0;
    sample();
    check("single_drop_gnt1", gnt1, 1);
    check("single_drop_we", fifo_we, 0);
    step();
    sample();
    check("single_idle_again", gnt1, 0);

    // Contention: alternating bursts of four
    step();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h20;
    step();
    for (int i = 0; i < 12; i++) begin
      sample();
      check("cont_we", fifo_we, 1);
      check("cont_data", fifo_data_in, exp_c[i]);
      check("cont_ack0", ack0, (exp_c[i][7:4] == 4'h1));
      check("cont_ack1", ack1, (exp_c[i][7:4] == 4'h2));
      step();
      if (exp_c[i][7:4] == 4'h1) data0 = data0 + 8'd1;
      else                       data1 = data1 + 8'd1;
    end

    // Full stall at burst_cnt=2
    do_reset();
    req0 = 1'b1; data0 = 8'h30; data1 = 8'h40;
    step();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("stall_pre_data", fifo_data_in, 8'h30 + i);
      check("stall_pre_we", fifo_we, 1);
      step();
      data0 = data0 + 8'd1;
    end
    fifo_full = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_we", fifo_we, 0);
      check("stall_gnt0", gnt0, 1);
      check("stall_gnt1", gnt1, 0);
      step();
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("stall_post_data", fifo_data_in, 8'h32 + i);
      check("stall_post_ack0", ack0, 1);
      step();
      data0 = data0 + 8'd1;
    end
    sample();
    check("stall_switch_gnt1", gnt1, 1);
    check("stall_switch_data", fifo_data_in, 8'h40);
    check("stall_switch_ack1", ack1, 1);

    // Request drop after one ack
    step();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h50; data1 = 8'h60;
    step();
    sample();
    check("drop_first_data", fifo_data_in, 8'h50);
    check("drop_first_ack0", ack0, 1);
    step();
    req0 = 1'b0;
    sample();
    check("drop_hole_we", fifo_we, 0);
    step();
    req0 = 1'b1; data0 = 8'h51;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("drop_gnt1", gnt1, 1);
      check("drop_data1", fifo_data_in, 8'h60 + i);
      check("drop_ack1", ack1, 1);
      step();
      data1 = data1 + 8'd1;
    end
    sample();
    check("drop_back_gnt0", gnt0, 1);
    check("drop_back_data", fifo_data_in, 8'h51);

    // Reset mid-burst in a GRANT1 ack cycle
    step();
    do_reset();
    req1 = 1'b1; data1 = 8'h70; data0 = 8'h80;
    step();
    sample();
    check("mid_ack1", ack1, 1);
    step();
    rst = 1'b1; data1 = 8'h71;
    sample();
    check("mid_rst_we", fifo_we, 0);
    check("mid_rst_ack1", ack1, 0);
    step();
    rst = 1'b0; req0 = 1'b1;
    sample();
    check("mid_idle_gnt0", gnt0, 0);
    check("mid_idle_gnt1", gnt1, 0);
    step();
    sample();
    check("mid_regrant_gnt0", gnt0, 1);
    check("mid_regrant_data", fifo_data_in, 8'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
